// File: rtl/gen_mpfifo.sv
`default_nettype none
// ============================================================================
// Module   : gen_mpfifo
// Brief    : Multi-lane FIFO, up to PUSH_W writes and POP_W reads per cycle.
// Revision : 1.0
// ============================================================================
module gen_mpfifo #(
    parameter int  DW     = 64,
    parameter int  AW     = 3,
    parameter int  PUSH_W = 2,
    parameter int  POP_W  = 2,
    localparam int DP     = 2 ** AW,
    localparam int CW     = AW + 1,
    localparam int PNW    = $clog2(PUSH_W + 1),
    localparam int QNW    = $clog2(POP_W + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 flush,
    input  logic [PNW-1:0]       push_num,
    input  logic [PUSH_W*DW-1:0] push_data,
    output logic                 push_ready,
    input  logic [QNW-1:0]       pop_num,
    output logic [POP_W*DW-1:0]  pop_data,
    output logic [POP_W-1:0]     pop_vld,
    output logic [QNW-1:0]       pop_done,
    output logic [CW-1:0]        count,
    output logic [CW-1:0]        free_cnt,
    output logic                 fifo_empty,
    output logic                 fifo_full,
    output logic [DP*DW-1:0]     expose_o,
    output logic [DP-1:0]        valid
);

    generate
        if (PUSH_W < 1 || PUSH_W > DP || POP_W < 1 || POP_W > DP) begin : g_param_check
            $error("gen_mpfifo: PUSH_W and POP_W must lie in 1..DP");
        end
    endgenerate

    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [DP-1:0] vld_q, vld_d;
    logic [DW-1:0] mem_q [DP];
    logic [DW-1:0] mem_d [DP];

    logic [PNW-1:0] push_clamp;
    logic [QNW-1:0] pop_clamp;
    logic [CW-1:0]  push_n;
    logic [CW-1:0]  pop_req;
    logic [CW-1:0]  pop_n;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  free;
    logic           push_acc;
    logic [DP-1:0]  we;

    // Out-of-range requests saturate rather than wrap.
    assign push_clamp = (push_num > PNW'(PUSH_W)) ? PNW'(PUSH_W) : push_num;
    assign pop_clamp  = (pop_num  > QNW'(POP_W))  ? QNW'(POP_W)  : pop_num;
    assign push_n     = CW'(push_clamp);
    assign pop_req    = CW'(pop_clamp);

    assign cnt        = wr_ptr_q - rd_ptr_q;
    assign free       = CW'(DP) - cnt;
    assign push_ready = (free >= push_n);
    assign push_acc   = push_ready && (push_n != '0);
    assign pop_n      = (pop_req < cnt) ? pop_req : cnt;

    assign count      = cnt;
    assign free_cnt   = free;
    assign fifo_empty = (cnt == '0);
    assign fifo_full  = (cnt == CW'(DP));
    assign pop_done   = QNW'(pop_n);
    assign valid      = vld_q;

    generate
        for (genvar j = 0; j < POP_W; j++) begin : g_pop_lane
            logic [AW-1:0] slot;
            assign slot                 = rd_ptr_q[AW-1:0] + AW'(j);
            assign pop_data[DW*j +: DW] = mem_q[slot];
            assign pop_vld[j]           = (CW'(j) < cnt);
        end

        for (genvar i = 0; i < DP; i++) begin : g_expose
            assign expose_o[DW*i +: DW] = mem_q[i];
        end
    endgenerate

    // Write enables; slot index wraps naturally in AW bits.
    always_comb begin
        we = '0;
        for (int i = 0; i < DP; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_acc && !flush) begin
            for (int k = 0; k < PUSH_W; k++) begin
                if (CW'(k) < push_n) begin
                    we[wr_ptr_q[AW-1:0] + AW'(k)]    = 1'b1;
                    mem_d[wr_ptr_q[AW-1:0] + AW'(k)] = push_data[DW*k +: DW];
                end
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        vld_d    = vld_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            vld_d    = '0;
        end else begin
            for (int j = 0; j < POP_W; j++) begin
                if (CW'(j) < pop_n) begin
                    vld_d[rd_ptr_q[AW-1:0] + AW'(j)] = 1'b0;
                end
            end
            vld_d    = vld_d | we;
            rd_ptr_d = rd_ptr_q + pop_n;
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + push_n;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DP; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            vld_q    <= vld_d;
            for (int i = 0; i < DP; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    a_push_num_legal: assert property (@(posedge CLK) disable iff (RST) push_num <= PNW'(PUSH_W))
        else $error("gen_mpfifo: push_num above PUSH_W");
    a_pop_num_legal: assert property (@(posedge CLK) disable iff (RST) pop_num <= QNW'(POP_W))
        else $error("gen_mpfifo: pop_num above POP_W");

endmodule
`default_nettype wire
